// File: rtl/exec_abs_add_branch_unit.sv
// Execute slice: ADD/SUB/ABS/CMP ALU with 1-cycle registered result, CZSV flag register,
// combinational J/JA branch resolution. Define EXEC_CARRY_OPS_EN to enable ADC/SBC.
`timescale 1ns/1ps
module exec_abs_add_branch_unit #(
  parameter int W_OPR = 32,
  parameter int ADDR  = 32,
  parameter int W_OPC = 7,
  parameter int W_RD  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             v_i,
  input  logic             stall_i,
  input  logic [ADDR-1:0]  pc_i,
  input  logic [W_OPC-1:0] opecode_i,
  input  logic [W_OPR-1:0] opr0_i,
  input  logic [W_OPR-1:0] opr1_i,
  input  logic             wb_i,
  input  logic [W_RD-1:0]  wb_r_i,
  output logic             v_o,
  output logic [W_OPR-1:0] result_o,
  output logic             wb_o,
  output logic [W_RD-1:0]  wb_r_o,
  output logic [3:0]       flags_o,
  output logic             branch_o,
  output logic [ADDR-1:0]  branch_addr_o
);
  localparam logic [W_OPC-1:0] OP_ADD = W_OPC'(7'b0000000);
  localparam logic [W_OPC-1:0] OP_SUB = W_OPC'(7'b0000001);
  localparam logic [W_OPC-1:0] OP_CMP = W_OPC'(7'b0000100);
  localparam logic [W_OPC-1:0] OP_ABS = W_OPC'(7'b0000101);
`ifdef EXEC_CARRY_OPS_EN
  localparam logic [W_OPC-1:0] OP_ADC = W_OPC'(7'b0000110);
  localparam logic [W_OPC-1:0] OP_SBC = W_OPC'(7'b0000111);
`endif
  localparam logic [W_OPC-1:0] OP_J   = W_OPC'(7'b0011100);
  localparam logic [W_OPC-1:0] OP_JA  = W_OPC'(7'b0011101);

  typedef struct packed {
    logic             v;
    logic [W_OPR-1:0] result;
    logic             wb;
    logic [W_RD-1:0]  wb_r;
  } ex_rsp_t;

  ex_rsp_t        rsp_q;
  logic [3:0]     flags_q;   // {C,Z,S,V}
  logic [W_OPR:0] sub_ext;
  logic [W_OPR-1:0] result;
  logic [3:0]     cmp_flags;
  logic           is_j, is_ja, cond, f_c, f_z, f_s, f_v, slt;

  assign {f_c, f_z, f_s, f_v} = flags_q;
  assign slt = f_s ^ f_v;

  always_comb begin
    // extra msb of the widened subtract is the borrow
    sub_ext   = {1'b0, opr0_i} - {1'b0, opr1_i};
    cmp_flags = {sub_ext[W_OPR], opr0_i == opr1_i, sub_ext[W_OPR-1],
                 (opr0_i[W_OPR-1] ^ opr1_i[W_OPR-1]) & (opr0_i[W_OPR-1] ^ sub_ext[W_OPR-1])};
    result = '0;
    case (opecode_i)
      OP_ADD:         result = opr0_i + opr1_i;
      OP_SUB, OP_CMP: result = sub_ext[W_OPR-1:0];
      OP_ABS:         result = opr0_i[W_OPR-1] ? ('0 - opr0_i) : opr0_i;
`ifdef EXEC_CARRY_OPS_EN
      OP_ADC:         result = opr0_i + opr1_i + W_OPR'(f_c);
      OP_SBC:         result = opr0_i - opr1_i - W_OPR'(f_c);
`endif
      default:        result = '0;
    endcase
  end

  always_comb begin
    is_j  = (opecode_i == OP_J);
    is_ja = (opecode_i == OP_JA);
    case (opr1_i[3:0])
      4'd0:    cond = 1'b1;
      4'd1:    cond = f_z;
      4'd2:    cond = ~f_z;
      4'd3:    cond = slt;
      4'd4:    cond = ~slt;
      4'd5:    cond = f_c;
      4'd6:    cond = ~f_c;
      4'd7:    cond = ~f_z & ~slt;
      4'd8:    cond = f_z | slt;
      default: cond = 1'b0;
    endcase
    branch_o      = v_i & (is_j | is_ja) & cond;
    branch_addr_o = '0;
    if (is_j)       branch_addr_o = pc_i + ADDR'(opr0_i);
    else if (is_ja) branch_addr_o = ADDR'(opr0_i);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                          flags_q <= '0;
    else if (v_i && !stall_i && opecode_i == OP_CMP)     flags_q <= cmp_flags;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rsp_q <= '0;
    else if (!stall_i) begin
      rsp_q.v      <= v_i;
      rsp_q.result <= result;
      rsp_q.wb     <= wb_i & v_i;
      rsp_q.wb_r   <= wb_r_i;
    end
  end

  assign v_o      = rsp_q.v;
  assign result_o = rsp_q.result;
  assign wb_o     = rsp_q.wb;
  assign wb_r_o   = rsp_q.wb_r;
  assign flags_o  = flags_q;
endmodule

// File: tb/tb_exec_abs_add_branch_unit.sv
// Scoreboard bench for exec_abs_add_branch_unit: driver queues expected writeback,
// negedge monitor pops on each advancing valid output; flags/branch checked directly.
`timescale 1ns/1ps
module tb_exec_abs_add_branch_unit;
  localparam logic [6:0] ADD = 7'b0000000, SUB = 7'b0000001, CMP = 7'b0000100,
                         ABS = 7'b0000101, ADC = 7'b0000110, SBC = 7'b0000111,
                         J   = 7'b0011100, JA  = 7'b0011101, BAD = 7'b0000010;
`ifdef EXEC_CARRY_OPS_EN
  localparam logic [31:0] ADC_EXP = 32'd3, SBC_EXP = 32'd3;
`else
  localparam logic [31:0] ADC_EXP = 32'd0, SBC_EXP = 32'd0;
`endif

  logic clk = 1'b0, reset, v_i, stall_i, wb_i;
  logic [31:0] pc_i, a, b;
  logic [6:0]  opc;
  logic [4:0]  wb_r_i;
  logic        v_o, wb_o, branch_o;
  logic [31:0] result_o, branch_addr_o;
  logic [4:0]  wb_r_o;
  logic [3:0]  flags_o;

  exec_abs_add_branch_unit dut (
    .clk(clk), .reset(reset), .v_i(v_i), .stall_i(stall_i), .pc_i(pc_i),
    .opecode_i(opc), .opr0_i(a), .opr1_i(b), .wb_i(wb_i), .wb_r_i(wb_r_i),
    .v_o(v_o), .result_o(result_o), .wb_o(wb_o), .wb_r_o(wb_r_o),
    .flags_o(flags_o), .branch_o(branch_o), .branch_addr_o(branch_addr_o));

  always #50 clk = ~clk;

  int checks = 0, errors = 0;
  typedef struct packed { logic [31:0] r; logic wb; logic [4:0] wbr; } exp_t;
  exp_t sb[$];
  logic adv = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [6:0] op, input logic [31:0] ia, ib, ipc,
                       input logic iv, iwb, input logic [4:0] iwr, input logic ist,
                       input logic [31:0] er);
    @(posedge clk); #1;
    opc = op; a = ia; b = ib; pc_i = ipc; v_i = iv; wb_i = iwb; wb_r_i = iwr; stall_i = ist;
    if (iv && !ist) sb.push_back(exp_t'{er, iwb, iwr});
  endtask

  // an output is new only if the edge that produced it was not stalled or in reset
  always @(posedge clk) adv = (stall_i === 1'b0) && (reset === 1'b1);

  always @(negedge clk) begin
    exp_t e;
    if (adv && v_o === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected: got result %h with no expected entry", result_o);
      end else begin
        e = sb.pop_front();
        chk("sb_result", {32'd0, result_o}, {32'd0, e.r});
        chk("sb_wb",     {63'd0, wb_o},     {63'd0, e.wb});
        chk("sb_wb_r",   {59'd0, wb_r_o},   {59'd0, e.wbr});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [15:0] cond_exp;

  initial begin
    reset = 1'b0; v_i = 0; stall_i = 0; wb_i = 0; pc_i = 0; a = 0; b = 0; opc = ADD; wb_r_i = 0;
    #1;
    chk("rst_v_o", 64'(v_o), 64'd0);
    chk("rst_result", 64'(result_o), 64'd0);
    chk("rst_wb_o", 64'(wb_o), 64'd0);
    chk("rst_wb_r", 64'(wb_r_o), 64'd0);
    chk("rst_flags", 64'(flags_o), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    issue(ADD, 32'hFFFFFFFF, 32'd1, 0, 1, 1, 3, 0, 32'd0);
    #1 chk("addr_non_branch", 64'(branch_addr_o), 64'd0);
    issue(ABS, 32'hFFFFFFFB, 0, 0, 1, 1, 4, 0, 32'd5);
    chk("flags_after_add", 64'(flags_o), 64'd0);
    issue(ABS, 32'h80000000, 0, 0, 1, 0, 7, 0, 32'h80000000);
    issue(SUB, 32'd5, 32'd7, 0, 1, 1, 1, 0, 32'hFFFFFFFE);
    issue(BAD, 32'd5, 32'd6, 0, 1, 1, 2, 0, 32'd0);
    chk("flags_after_sub", 64'(flags_o), 64'd0);

    // CMP 3,5 -> C=1 Z=0 S=1 V=0; branch sees it on the very next instruction
    issue(CMP, 32'd3, 32'd5, 0, 1, 0, 0, 0, 32'hFFFFFFFE);
    issue(J, 32'h20, 32'd5, 32'h100, 1, 0, 0, 0, 32'd0);
    #1;
    chk("flags_cmp_lt", 64'(flags_o), 64'hA);
    chk("j_taken", 64'(branch_o), 64'd1);
    chk("j_addr", 64'(branch_addr_o), 64'h120);
    cond_exp = 16'h012D;
    for (int i = 0; i < 16; i++) begin
      b = 32'(i); #1;
      chk($sformatf("cond_%0d", i), 64'(branch_o), 64'(cond_exp[i]));
    end
    v_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      b = 32'(i); #1;
      chk($sformatf("novalid_cond_%0d", i), 64'(branch_o), 64'd0);
    end
    v_i = 1'b1; b = 32'd5;

    issue(CMP, 32'd7, 32'd7, 0, 1, 0, 0, 0, 32'd0);
    issue(JA, 32'h400, 32'd2, 32'h100, 1, 0, 0, 0, 32'd0);
    #1;
    chk("flags_cmp_eq", 64'(flags_o), 64'h4);
    chk("ja_not_taken", 64'(branch_o), 64'd0);
    chk("ja_addr", 64'(branch_addr_o), 64'h400);
    b = 32'd1; #1;
    chk("ja_z_taken", 64'(branch_o), 64'd1);
    b = 32'd2;

    // stall: hold result 30 and the CMP 7,7 flags while ADD 1,2 / CMP 3,5 are presented
    issue(ADD, 32'd10, 32'd20, 0, 1, 1, 6, 0, 32'd30);
    issue(ADD, 32'd1, 32'd2, 0, 1, 1, 9, 1, 32'd0);
    issue(CMP, 32'd3, 32'd5, 0, 1, 0, 0, 1, 32'd0);
    #1;
    chk("stall_result_hold", 64'(result_o), 64'd30);
    chk("stall_v_hold", 64'(v_o), 64'd1);
    chk("stall_wb_r_hold", 64'(wb_r_o), 64'd6);
    issue(ADD, 32'd1, 32'd2, 0, 1, 1, 9, 0, 32'd3);
    #1 chk("stall_flags_hold", 64'(flags_o), 64'h4);

    issue(CMP, 32'h80000000, 32'd1, 0, 1, 0, 0, 0, 32'h7FFFFFFF);
    issue(ADD, 0, 0, 0, 0, 0, 0, 0, 32'd0);
    #1 chk("flags_cmp_ovf", 64'(flags_o), 64'h1);

    issue(CMP, 32'd3, 32'd5, 0, 1, 0, 0, 0, 32'hFFFFFFFE);
    issue(ADC, 32'd1, 32'd1, 0, 1, 1, 10, 0, ADC_EXP);
    issue(SBC, 32'd5, 32'd1, 0, 1, 1, 11, 0, SBC_EXP);

    // asynchronous reset in the middle of a stall
    issue(ADD, 32'd4, 32'd4, 0, 1, 1, 2, 0, 32'd8);
    @(posedge clk); #1;
    v_i = 1'b0; stall_i = 1'b1;
    @(negedge clk); #2;
    reset = 1'b0; #1;
    chk("midrst_v_o", 64'(v_o), 64'd0);
    chk("midrst_result", 64'(result_o), 64'd0);
    chk("midrst_wb_o", 64'(wb_o), 64'd0);
    chk("midrst_wb_r", 64'(wb_r_o), 64'd0);
    chk("midrst_flags", 64'(flags_o), 64'd0);
    opc = J; a = 32'h20; pc_i = 32'h100; v_i = 1'b1; b = 32'd0; #1;
    chk("rst_branch_always", 64'(branch_o), 64'd1);
    b = 32'd1; #1;
    chk("rst_branch_z", 64'(branch_o), 64'd0);
    v_i = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; stall_i = 1'b0;

    issue(ADD, 32'd7, 32'd8, 0, 1, 1, 5, 0, 32'd15);
    issue(ADD, 0, 0, 0, 0, 0, 0, 0, 32'd0);
    @(posedge clk); @(negedge clk); #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
